// File: rtl/motoro3_step_decoder_if.sv
// motoro3_step_decoder_if
//   Bundles the 3-phase commutation drive lines, the statistics clear and
//   the decoder's status outputs.
//   master : drives the phase lines and clr, observes the decoder status.
//   slave  : the decoder itself.
interface motoro3_step_decoder_if;
    // phase drive lines (asynchronous to clk) and statistics clear
    logic        aE, aH1_L0, bE, bH1_L0, cE, cH1_L0;
    logic        clr;
    // decoder status
    logic [3:0]  decStep;
    logic        decValid;
    logic        decDir;
    logic [24:0] stepPeriod;
    logic        periodValid;
    logic [31:0] roundCnt;
    logic [15:0] errCnt;
    logic        seqErr;
    logic        stall;

    modport master (
        output aE, aH1_L0, bE, bH1_L0, cE, cH1_L0, clr,
        input  decStep, decValid, decDir, stepPeriod, periodValid,
               roundCnt, errCnt, seqErr, stall
    );

    modport slave (
        input  aE, aH1_L0, bE, bH1_L0, cE, cH1_L0, clr,
        output decStep, decValid, decDir, stepPeriod, periodValid,
               roundCnt, errCnt, seqErr, stall
    );
endinterface

// File: rtl/motoro3_step_decoder.sv
// motoro3_step_decoder
//   Receive-side monitor for the 3-phase commutation bus. Synchronises the
//   six phase lines, decodes the commutation step, deglitches it, checks
//   sequence legality/direction, measures step dwell and counts rounds.
// Ports
//   clk  : system clock, rising edge
//   nRst : asynchronous active-low reset
//   bus  : slave side of motoro3_step_decoder_if (phase lines + clr in,
//          decStep/decValid/decDir/stepPeriod/periodValid/roundCnt/
//          errCnt/seqErr/stall out)
module motoro3_step_decoder #(
    parameter int unsigned FILT_LEN = 4,
    parameter logic [24:0] TIMEOUT  = 25'd2_000_000
) (
    input  logic                   clk,
    input  logic                   nRst,
    motoro3_step_decoder_if.slave  bus
);

    localparam logic [7:0]  FL   = 8'(FILT_LEN);
    localparam logic [24:0] PMAX = 25'h1FF_FFFF;

    typedef enum logic [2:0] {
        EV_NONE, EV_IDLE, EV_BAD, EV_START, EV_FWD, EV_REV, EV_JUMP
    } ev_t;

    function automatic logic is_norm(input logic [3:0] s);
        return (s >= 4'd1) && (s <= 4'd6);
    endfunction

    // {E a,b,c , H a,b,c}
    logic [5:0]  lines, sync1, sync2;
    logic [3:0]  decoded, cand;
    logic [7:0]  filtCnt, filt_nxt;
    logic        accept;
    logic [3:0]  step_up, step_dn;
    ev_t         ev;

    logic [3:0]  decStep;
    logic        decValid, decDir, periodValid, seqErr, stall;
    logic [24:0] stepPeriod, periodCnt;
    logic [31:0] roundCnt;
    logic [15:0] errCnt;

    assign lines = {bus.aE, bus.bE, bus.cE, bus.aH1_L0, bus.bH1_L0, bus.cH1_L0};

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= lines;
            sync2 <= sync1;
        end
    end

    always_comb begin
        decoded = 4'd15;
        if (sync2[5:3] == 3'b111) begin
            case (sync2[2:0])
                3'b100:  decoded = 4'd1;
                3'b110:  decoded = 4'd2;
                3'b010:  decoded = 4'd3;
                3'b011:  decoded = 4'd4;
                3'b001:  decoded = 4'd5;
                3'b101:  decoded = 4'd6;
                default: decoded = 4'd15;
            endcase
        end else if (sync2 == 6'b000000) begin
            decoded = 4'd0;
        end
    end

    // Acceptance is evaluated on the counter's next value so the filter
    // reaching FILT_LEN and the decStep update land on the same edge; this
    // gives a pin-to-decStep latency of 2 sync + FILT_LEN filter cycles.
    // The accepted value is 'decoded', which equals cand whenever the
    // filter is past its first cycle.
    always_comb begin
        if (decoded != cand)   filt_nxt = 8'd1;
        else if (filtCnt >= FL) filt_nxt = FL;
        else                   filt_nxt = filtCnt + 8'd1;
        accept = (filt_nxt == FL) && (decoded != decStep);
    end

    // Event classification of an accepted step (next-state logic)
    always_comb begin
        step_up = (decStep == 4'd6) ? 4'd1 : decStep + 4'd1;
        step_dn = (decStep == 4'd1) ? 4'd6 : decStep - 4'd1;
        ev      = EV_NONE;
        if (accept) begin
            if (decoded == 4'd0)          ev = EV_IDLE;
            else if (decoded == 4'd15)    ev = EV_BAD;
            else if (!is_norm(decStep))   ev = EV_START;
            else if (decoded == step_up)  ev = EV_FWD;
            else if (decoded == step_dn)  ev = EV_REV;
            else                          ev = EV_JUMP;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cand        <= '0;
            filtCnt     <= '0;
            decStep     <= '0;
            decValid    <= 1'b0;
            decDir      <= 1'b0;
            stepPeriod  <= '0;
            periodValid <= 1'b0;
            periodCnt   <= '0;
            roundCnt    <= '0;
            errCnt      <= '0;
            seqErr      <= 1'b0;
            stall       <= 1'b0;
        end else begin
            cand     <= decoded;
            filtCnt  <= filt_nxt;
            decValid <= accept;
            seqErr   <= 1'b0;

            if (accept) begin
                decStep <= decoded;
                stall   <= 1'b0;
                case (ev)
                    EV_IDLE: begin
                        periodCnt   <= '0;
                        periodValid <= 1'b0;
                        roundCnt    <= '0;
                    end
                    EV_BAD: begin
                        seqErr      <= 1'b1;
                        if (errCnt != 16'hFFFF) errCnt <= errCnt + 16'd1;
                        periodValid <= 1'b0;
                        periodCnt   <= '0;
                    end
                    EV_START: periodCnt <= 25'd1;
                    EV_FWD, EV_REV: begin
                        decDir      <= (ev == EV_FWD);
                        stepPeriod  <= periodCnt;
                        periodValid <= 1'b1;
                        periodCnt   <= 25'd1;
                        if (ev == EV_FWD && decStep == 4'd6)
                            roundCnt <= roundCnt + 32'd1;
                        if (ev == EV_REV && decStep == 4'd1 && roundCnt != '0)
                            roundCnt <= roundCnt - 32'd1;
                    end
                    EV_JUMP: begin
                        seqErr      <= 1'b1;
                        if (errCnt != 16'hFFFF) errCnt <= errCnt + 16'd1;
                        periodValid <= 1'b0;
                        periodCnt   <= 25'd1;
                    end
                    default: ;
                endcase
            end else if (is_norm(decStep)) begin
                if (periodCnt != PMAX)     periodCnt <= periodCnt + 25'd1;
                if (periodCnt == TIMEOUT)  stall     <= 1'b1;
            end

            // clr overrides every statistic it owns, even on an accept edge
            if (bus.clr) begin
                errCnt      <= '0;
                roundCnt    <= '0;
                stepPeriod  <= '0;
                periodValid <= 1'b0;
                stall       <= 1'b0;
                seqErr      <= 1'b0;
            end
        end
    end

    assign bus.decStep     = decStep;
    assign bus.decValid    = decValid;
    assign bus.decDir      = decDir;
    assign bus.stepPeriod  = stepPeriod;
    assign bus.periodValid = periodValid;
    assign bus.roundCnt    = roundCnt;
    assign bus.errCnt      = errCnt;
    assign bus.seqErr      = seqErr;
    assign bus.stall       = stall;

endmodule

// File: tb/tb_motoro3_step_decoder.sv
module tb_motoro3_step_decoder;

    logic clk;
    logic nRst;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [3:0] step;
        logic       dir;
    } exp_t;
    exp_t q[$];

    motoro3_step_decoder_if bus();

    motoro3_step_decoder #(.FILT_LEN(4), .TIMEOUT(25'd300)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_lines(input logic [2:0] e, input logic [2:0] h);
        {bus.aE, bus.bE, bus.cE}             = e;
        {bus.aH1_L0, bus.bH1_L0, bus.cH1_L0} = h;
    endtask

    task automatic set_step(input int s);
        case (s)
            1: set_lines(3'b111, 3'b100);
            2: set_lines(3'b111, 3'b110);
            3: set_lines(3'b111, 3'b010);
            4: set_lines(3'b111, 3'b011);
            5: set_lines(3'b111, 3'b001);
            6: set_lines(3'b111, 3'b101);
            default: set_lines(3'b000, 3'b000);
        endcase
    endtask

    task automatic expect_ev(input logic [3:0] s, input logic d);
        exp_t e;
        e.step = s;
        e.dir  = d;
        q.push_back(e);
    endtask

    // Scoreboard: every decValid pulse must match the oldest expected event
    always @(negedge clk) begin
        if (nRst && bus.decValid) begin
            exp_t e;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_decValid observed step %0d expected no event", bus.decStep);
            end else begin
                e = q.pop_front();
                chk("ev_step", 32'(bus.decStep), 32'(e.step));
                chk("ev_dir",  32'(bus.decDir),  32'(e.dir));
            end
        end
    end

    initial begin
        nRst = 1'b0;
        bus.clr = 1'b0;
        set_step(0);
        hold(3);
        nRst = 1'b1;
        hold(1);
        chk("rst_step",   32'(bus.decStep), 32'd0);
        chk("rst_valid",  32'(bus.decValid), 32'd0);
        chk("rst_round",  bus.roundCnt, 32'd0);
        chk("rst_err",    32'(bus.errCnt), 32'd0);
        chk("rst_period", 32'(bus.stepPeriod), 32'd0);
        chk("rst_pvalid", 32'(bus.periodValid), 32'd0);
        chk("rst_stall",  32'(bus.stall), 32'd0);
        chk("rst_seqerr", 32'(bus.seqErr), 32'd0);
        hold(30);
        chk("idle_step", 32'(bus.decStep), 32'd0);

        // forward: first entry with latency check, then 2..6,1..6,1
        expect_ev(4'd1, 1'b0);
        set_step(1);
        hold(5);
        chk("lat_early", 32'(bus.decValid), 32'd0);
        hold(1);
        chk("lat_valid", 32'(bus.decValid), 32'd1);
        chk("lat_step",  32'(bus.decStep), 32'd1);
        hold(994);
        for (int k = 2; k <= 13; k++) begin
            int s;
            s = ((k - 1) % 6) + 1;
            expect_ev(4'(s), 1'b1);
            set_step(s);
            hold(1000);
            if (k == 3) chk("fwd_period_2nd", 32'(bus.stepPeriod), 32'd1000);
        end
        chk("fwd_round",  bus.roundCnt, 32'd2);
        chk("fwd_dir",    32'(bus.decDir), 32'd1);
        chk("fwd_period", 32'(bus.stepPeriod), 32'd1000);
        chk("fwd_pvalid", 32'(bus.periodValid), 32'd1);
        chk("fwd_err",    32'(bus.errCnt), 32'd0);

        // reverse: 6,5,4,3,2,1,6,5,4,3,2,1,6 at 500 cycles
        for (int k = 0; k <= 12; k++) begin
            int s;
            s = 6 - (k % 6);
            expect_ev(4'(s), 1'b0);
            set_step(s);
            hold(500);
            if (k == 0)  chk("rev_round_a", bus.roundCnt, 32'd1);
            if (k == 6)  chk("rev_round_b", bus.roundCnt, 32'd0);
            if (k == 12) chk("rev_round_sat", bus.roundCnt, 32'd0);
        end
        chk("rev_dir",    32'(bus.decDir), 32'd0);
        chk("rev_period", 32'(bus.stepPeriod), 32'd500);
        chk("rev_err",    32'(bus.errCnt), 32'd0);

        // glitch then illegal jump 2 -> 5
        expect_ev(4'd1, 1'b1); set_step(1); hold(200);
        expect_ev(4'd2, 1'b1); set_step(2); hold(200);
        chk("gl_round", bus.roundCnt, 32'd1);
        set_step(5); hold(3);
        set_step(2); hold(100);
        chk("gl_step", 32'(bus.decStep), 32'd2);
        chk("gl_err",  32'(bus.errCnt), 32'd0);
        expect_ev(4'd5, 1'b1);
        set_step(5);
        hold(6);
        chk("jump_seqerr", 32'(bus.seqErr), 32'd1);
        chk("jump_err",    32'(bus.errCnt), 32'd1);
        chk("jump_pvalid", 32'(bus.periodValid), 32'd0);
        chk("jump_step",   32'(bus.decStep), 32'd5);
        hold(1);
        chk("jump_seqerr_off", 32'(bus.seqErr), 32'd0);
        hold(100);

        // stall: hold step 3 for 310 cycles with TIMEOUT 300
        expect_ev(4'd4, 1'b0); set_step(4); hold(100);
        expect_ev(4'd3, 1'b0); set_step(3);
        hold(305);
        chk("stall_pre", 32'(bus.stall), 32'd0);
        hold(1);
        chk("stall_set", 32'(bus.stall), 32'd1);
        hold(4);
        expect_ev(4'd4, 1'b1);
        set_step(4);
        hold(6);
        chk("stall_clr",    32'(bus.stall), 32'd0);
        chk("stall_period", 32'(bus.stepPeriod), 32'd310);
        chk("stall_pvalid", 32'(bus.periodValid), 32'd1);
        hold(50);

        // invalid pattern E=110
        expect_ev(4'd15, 1'b1);
        set_lines(3'b110, 3'b000);
        hold(6);
        chk("bad_step",   32'(bus.decStep), 32'd15);
        chk("bad_err",    32'(bus.errCnt), 32'd2);
        chk("bad_seqerr", 32'(bus.seqErr), 32'd1);
        chk("bad_pvalid", 32'(bus.periodValid), 32'd0);
        hold(50);

        // clr coincident with accept of step 1
        expect_ev(4'd1, 1'b1);
        set_step(1);
        hold(5);
        bus.clr = 1'b1;
        hold(1);
        bus.clr = 1'b0;
        chk("clr_step",  32'(bus.decStep), 32'd1);
        chk("clr_valid", 32'(bus.decValid), 32'd1);
        chk("clr_err",   32'(bus.errCnt), 32'd0);
        chk("clr_round", bus.roundCnt, 32'd0);
        hold(50);

        // back to idle
        expect_ev(4'd0, 1'b1);
        set_step(0);
        hold(20);
        chk("idle2_step",   32'(bus.decStep), 32'd0);
        chk("idle2_pvalid", 32'(bus.periodValid), 32'd0);

        // reset mid-step, then the held pattern re-enters as start-up
        expect_ev(4'd2, 1'b1); set_step(2); hold(100);
        expect_ev(4'd3, 1'b1); set_step(3); hold(100);
        #3;
        nRst = 1'b0;
        #1;
        chk("mid_rst_step",   32'(bus.decStep), 32'd0);
        chk("mid_rst_dir",    32'(bus.decDir), 32'd0);
        chk("mid_rst_period", 32'(bus.stepPeriod), 32'd0);
        hold(2);
        nRst = 1'b1;
        expect_ev(4'd3, 1'b0);
        hold(20);
        chk("post_rst_step", 32'(bus.decStep), 32'd3);
        chk("queue_empty",   32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
